// File: rtl/clk_enable_synth_pkg.sv
// ----------------------------------------------------------------------------
// clk_enable_synth_pkg
// Shared types and helpers for the clock-enable synthesiser.
//   state_t   : supervisor states (reset, settling after a (re)configuration,
//               locked and producing enables)
//   ch_width  : index width for n items, never narrower than one bit
// ----------------------------------------------------------------------------
package clk_enable_synth_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // $clog2(1) is 0, but a zero-width index bus is not legal, so floor at 1.
  function automatic int ch_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/clk_enable_synth_if.sv
// ----------------------------------------------------------------------------
// clk_enable_synth_if
// Configuration bus of the clock-enable synthesiser.
//   cfg_valid  : shadow-register write request          (master -> slave)
//   cfg_ready  : write accepted when valid && ready      (slave  -> master)
//   cfg_chan   : target channel index                    (master -> slave)
//   cfg_incr   : frequency word, 0 stops the channel     (master -> slave)
//   cfg_phase  : start phase applied on commit           (master -> slave)
//   cfg_commit : copy all shadows to active, relock      (master -> slave)
//   cfg_err    : one-cycle pulse, accepted write was out of range
// ----------------------------------------------------------------------------
interface clk_enable_synth_if
  import clk_enable_synth_pkg::*;
#(
  parameter int NUM_CLOCKS = 3,
  parameter int ACC_W      = 32
) ();

  localparam int CH_W = ch_width(NUM_CLOCKS);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [ACC_W-1:0] cfg_incr;
  logic [ACC_W-1:0] cfg_phase;
  logic             cfg_commit;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_incr,
    output cfg_phase,
    output cfg_commit,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_incr,
    input  cfg_phase,
    input  cfg_commit,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/clk_enable_synth_chan.sv
// ----------------------------------------------------------------------------
// clk_enable_synth_chan
// One phase-accumulator channel.
//   clk    : fabric clock
//   rst    : synchronous active-high reset
//   run    : advance the accumulator this cycle
//   load   : take phase/incr as the new start phase and active frequency word
//   phase  : start phase applied on load
//   incr   : frequency word applied on load
//   clken  : registered carry of the accumulator add (one pulse per wrap)
//   clkout : accumulator MSB, roughly 50% duty square wave
// Output gating while not locked is done by the caller.
// ----------------------------------------------------------------------------
module clk_enable_synth_chan #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [ACC_W-1:0] phase,
  input  logic [ACC_W-1:0] incr,
  output logic             clken,
  output logic             clkout
);

  logic [ACC_W-1:0] incr_act;
  logic [ACC_W-1:0] acc_p0;
  logic [ACC_W:0]   sum_p0;
  logic             clken_p1;

  // Extra top bit of the add is the wrap indication; the low bits wrap
  // modulo 2^ACC_W, which keeps the long-run pulse rate exact.
  assign sum_p0 = {1'b0, acc_p0} + {1'b0, incr_act};

  // ---- stage p0 -> p1: accumulate and register the carry ----
  always_ff @(posedge clk) begin
    if (rst) begin
      incr_act <= '0;
      acc_p0   <= '0;
      clken_p1 <= 1'b0;
    end else if (load) begin
      // Load wins over run so a commit while locked restarts cleanly.
      incr_act <= incr;
      acc_p0   <= phase;
      clken_p1 <= 1'b0;
    end else if (run) begin
      acc_p0   <= sum_p0[ACC_W-1:0];
      clken_p1 <= sum_p0[ACC_W];
    end else begin
      clken_p1 <= 1'b0;
    end
  end

  assign clken  = clken_p1;
  assign clkout = acc_p0[ACC_W-1];

endmodule

// File: rtl/clk_enable_synth.sv
// ----------------------------------------------------------------------------
// clk_enable_synth
// Multi-channel clock-enable synthesiser. Each channel is a phase
// accumulator whose wrap produces a one-cycle enable and whose MSB is a
// square wave; frequency = f_refclk * incr / 2^ACC_W. A supervisor FSM
// holds outputs off for LOCK_CYCLES after reset and after every commit.
//   refclk : sole clock
//   rst    : synchronous active-high reset
//   cfg    : configuration bus (slave side), see clk_enable_synth_if
//   clken  : per-channel one-cycle enable per accumulator wrap
//   clkout : per-channel accumulator MSB
//   locked : outputs valid and phase-aligned
// ----------------------------------------------------------------------------
module clk_enable_synth
  import clk_enable_synth_pkg::*;
#(
  parameter int NUM_CLOCKS  = 3,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                  refclk,
  input  logic                  rst,
  clk_enable_synth_if.slave     cfg,
  output logic [NUM_CLOCKS-1:0] clken,
  output logic [NUM_CLOCKS-1:0] clkout,
  output logic                  locked
);

  localparam int CH_W  = ch_width(NUM_CLOCKS);
  localparam int CNT_W = ch_width(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CH_W:0]    CHAN_LIM  = (CH_W + 1)'(NUM_CLOCKS);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic wr_acc;
  logic chan_ok;
  logic wr_ok;
  logic commit_acc;
  logic err_q;

  logic [NUM_CLOCKS-1:0] clken_raw;
  logic [NUM_CLOCKS-1:0] clkout_raw;

  assign cfg.cfg_ready = (state != ST_RESET);
  assign cfg.cfg_err   = err_q;

  assign wr_acc     = cfg.cfg_valid && cfg.cfg_ready;
  assign chan_ok    = ({1'b0, cfg.cfg_chan} < CHAN_LIM);
  assign wr_ok      = wr_acc && chan_ok;
  assign commit_acc = cfg.cfg_commit && (state != ST_RESET);

  assign locked = (state == ST_LOCKED);

  // ---- supervisor state register ----
  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= ST_RESET;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_RESET: begin
        state_nxt = ST_SETTLE;
        cnt_nxt   = '0;
      end
      ST_SETTLE: begin
        if (commit_acc) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_LOCKED;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (commit_acc) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_RESET;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---- out-of-range write flag, visible the cycle after the write ----
  always_ff @(posedge refclk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= wr_acc && !chan_ok;
    end
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    logic             sel;
    logic [ACC_W-1:0] shadow_incr;
    logic [ACC_W-1:0] shadow_phase;
    logic [ACC_W-1:0] incr_nxt;
    logic [ACC_W-1:0] phase_nxt;

    // The channel is fed the post-write shadow value so a write and a
    // commit in the same cycle commit the freshly written word.
    assign sel       = wr_ok && (cfg.cfg_chan == CH_W'(i));
    assign incr_nxt  = sel ? cfg.cfg_incr  : shadow_incr;
    assign phase_nxt = sel ? cfg.cfg_phase : shadow_phase;

    // ---- shadow registers ----
    always_ff @(posedge refclk) begin
      if (rst) begin
        shadow_incr  <= '0;
        shadow_phase <= '0;
      end else begin
        shadow_incr  <= incr_nxt;
        shadow_phase <= phase_nxt;
      end
    end

    clk_enable_synth_chan #(
      .ACC_W (ACC_W)
    ) u_chan (
      .clk    (refclk),
      .rst    (rst),
      .run    (locked),
      .load   (commit_acc),
      .phase  (phase_nxt),
      .incr   (incr_nxt),
      .clken  (clken_raw[i]),
      .clkout (clkout_raw[i])
    );
  end

  // Nothing leaves the block unless the supervisor reports lock.
  assign clken  = clken_raw  & {NUM_CLOCKS{locked}};
  assign clkout = clkout_raw & {NUM_CLOCKS{locked}};

endmodule

// File: tb/tb_clk_enable_synth.sv
// ----------------------------------------------------------------------------
// tb_clk_enable_synth
// Directed bench for clk_enable_synth (NUM_CLOCKS=3, ACC_W=32,
// LOCK_CYCLES=16). Expected values are hand-derived from the accumulator
// arithmetic; outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_clk_enable_synth;
  import clk_enable_synth_pkg::*;

  localparam int NUM_CLOCKS  = 3;
  localparam int ACC_W       = 32;
  localparam int LOCK_CYCLES = 16;

  logic                  refclk = 1'b0;
  logic                  rst;
  logic [NUM_CLOCKS-1:0] clken;
  logic [NUM_CLOCKS-1:0] clkout;
  logic                  locked;

  int err_cnt = 0;
  int chk_cnt = 0;

  clk_enable_synth_if #(.NUM_CLOCKS(NUM_CLOCKS), .ACC_W(ACC_W)) cfg_if ();

  clk_enable_synth #(
    .NUM_CLOCKS  (NUM_CLOCKS),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .cfg    (cfg_if),
    .clken  (clken),
    .clkout (clkout),
    .locked (locked)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [31:0] inc, input logic [31:0] ph,
                    input logic com);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_chan   = ch;
    cfg_if.cfg_incr   = inc;
    cfg_if.cfg_phase  = ph;
    cfg_if.cfg_commit = com;
    tick();
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_commit = 1'b0;
  endtask

  task automatic commit();
    cfg_if.cfg_commit = 1'b1;
    tick();
    cfg_if.cfg_commit = 1'b0;
  endtask

  // Called right after the edge that started SETTLE (commit or first edge
  // out of reset): locked must stay low 15 more cycles, rise on the 16th,
  // and clken/clkout must stay gated low the whole time.
  task automatic wait_lock(input string tag);
    logic seen;
    seen = |{clken, clkout};
    for (int k = 1; k < LOCK_CYCLES; k++) begin
      tick();
      seen = seen | (|{clken, clkout});
    end
    check({tag, "_pre"}, locked, 1'b0);
    check({tag, "_gated"}, seen, 1'b0);
    tick();
    check({tag, "_lock"}, locked, 1'b1);
  endtask

  initial begin
    logic [7:0] exp_en;
    logic [7:0] exp_out;
    logic [2:0] tab_en  [5];
    logic [2:0] tab_out [5];
    int         pulses;
    int         last;
    int         min_sp;
    int         max_sp;
    logic       seen;

    rst               = 1'b1;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_chan   = '0;
    cfg_if.cfg_incr   = '0;
    cfg_if.cfg_phase  = '0;
    cfg_if.cfg_commit = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_locked", locked, 1'b0);
    check("rst_clken", clken, 3'b000);
    check("rst_clkout", clkout, 3'b000);
    check("rst_ready", cfg_if.cfg_ready, 1'b0);
    check("rst_err", cfg_if.cfg_err, 1'b0);

    // Release: first edge with rst low enters SETTLE
    rst = 1'b0;
    tick();
    check("ready_up", cfg_if.cfg_ready, 1'b1);
    wait_lock("boot");
    check("boot_clken", clken, 3'b000);
    check("boot_clkout", clkout, 3'b000);

    // ch0 at f/4 (incr = 2^30): clken every 4th cycle, clkout 2 high of 4
    wr(2'd0, 32'h4000_0000, 32'h0, 1'b0);
    check("err_quiet", cfg_if.cfg_err, 1'b0);
    check("wr_nodisturb", locked, 1'b1);
    commit();
    check("commit_unlock", locked, 1'b0);
    wait_lock("p4");
    exp_en  = 8'h88;
    exp_out = 8'h66;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("p4_clken_%0d", k + 1), clken[0], exp_en[k]);
      check($sformatf("p4_clkout_%0d", k + 1), clkout[0], exp_out[k]);
    end

    // ch1 at ~f/3 with write+commit in one cycle
    wr(2'd1, 32'h5555_5555, 32'h0, 1'b1);
    check("ch1_unlock", locked, 1'b0);
    wait_lock("ch1");
    pulses = 0;
    last   = -1;
    min_sp = 1000;
    max_sp = 0;
    for (int k = 0; k < 3072; k++) begin
      tick();
      if (clken[1]) begin
        pulses++;
        if (last >= 0) begin
          if (k - last < min_sp) min_sp = k - last;
          if (k - last > max_sp) max_sp = k - last;
        end
        last = k;
      end
    end
    check("ch1_count", (pulses == 1023) || (pulses == 1024), 1'b1);
    check("ch1_min_sp", min_sp >= 3, 1'b1);
    check("ch1_max_sp", max_sp <= 4, 1'b1);

    // Out-of-range write: error pulse, no shadow change
    wr(2'd3, 32'h0, 32'hFFFF_FFFF, 1'b0);
    check("err_pulse", cfg_if.cfg_err, 1'b1);
    tick();
    check("err_clear", cfg_if.cfg_err, 1'b0);

    // Same-cycle write+commit to ch2 (incr = phase = 2^31)
    wr(2'd2, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_lock("ch2");
    tab_en  = '{3'b000, 3'b100, 3'b000, 3'b100, 3'b011};
    tab_out = '{3'b100, 3'b000, 3'b111, 3'b011, 3'b100};
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      check($sformatf("mix_clken_%0d", k), clken, tab_en[k]);
      check($sformatf("mix_clkout_%0d", k), clkout, tab_out[k]);
    end

    // Commit at cycle 5 of SETTLE restarts the count
    commit();
    repeat (5) tick();
    commit();
    wait_lock("recommit");

    // Reset while running
    repeat (2) tick();
    check("pre_rst_clkout", clkout, 3'b111);
    rst = 1'b1;
    tick();
    check("mid_rst_locked", locked, 1'b0);
    check("mid_rst_clken", clken, 3'b000);
    check("mid_rst_clkout", clkout, 3'b000);
    check("mid_rst_ready", cfg_if.cfg_ready, 1'b0);
    rst = 1'b0;
    tick();
    wait_lock("post_rst");
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      seen = seen | (|{clken, clkout});
    end
    check("post_rst_silent", seen, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/clk_enable_synth.md
# clk_enable_synth

Parametrised multi-channel clock-enable synthesiser for a core's clock tree. It generates NUM_CLOCKS independent, runtime-programmable clock enables plus square-wave phase outputs from one fabric clock, using per-channel phase accumulators. A supervisor state machine drives a `locked` indication that restarts on every reconfiguration. Core clocking stays on a single PLL output, and video/audio/CPU rates are derived in logic and can be retuned per system mode (e.g. NTSC/PAL, turbo) without PLL reconfiguration.

## Interface
- NUM_CLOCKS, 3, number of output channels (1..16)
- ACC_W, 32, phase accumulator width; channel frequency = f_refclk * incr / 2^ACC_W
- LOCK_CYCLES, 16, settle cycles before `locked` asserts (>= 1)
- CH_W, $clog2(NUM_CLOCKS) (minimum 1), channel index width (derived, not overridden)

Ports:
- refclk  in  1  sole clock
- rst  in  1  synchronous reset, active-high
- cfg_valid  in  1  shadow-register write request
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready
- cfg_chan  in  CH_W  target channel
- cfg_incr  in  ACC_W  frequency word (0 = channel stopped)
- cfg_phase  in  ACC_W  start phase loaded on commit
- cfg_commit  in  1  pulse: copy all shadows to active, restart lock sequence
- cfg_err  out  1  one-cycle pulse: accepted write had cfg_chan >= NUM_CLOCKS
- clken  out  NUM_CLOCKS  one-cycle enable per accumulator wrap
- clkout  out  NUM_CLOCKS  accumulator MSB (about 50% duty square)
- locked  out  1  outputs valid and phase-aligned

## Operation
- Per channel: shadow_incr, shadow_phase, active_incr, acc. All are 0 after reset.
- Write: on cfg_valid && cfg_ready with cfg_chan < NUM_CLOCKS, load the shadows of that channel. With cfg_chan out of range, drop the write and pulse cfg_err next cycle.
- Commit: copy the shadows of all channels to active_incr in the same cycle, and load acc with shadow_phase.
- If a write and cfg_commit occur in the same cycle, the commit uses the newly written value.
- States:
  - RESET: entered while rst is high; leaves on the first cycle rst is low.
  - SETTLE: counter runs 0..LOCK_CYCLES-1; go to LOCKED when it reaches LOCK_CYCLES-1.
  - LOCKED: steady state.
  - cfg_commit in SETTLE or LOCKED goes to SETTLE with the counter cleared; a commit in SETTLE restarts the count.
- Accumulators advance only in LOCKED: {carry, acc} <= acc + active_incr (ACC_W+1-bit add, modulo 2^ACC_W). In SETTLE they hold their loaded phase.
- clken[i] <= carry, registered. When not LOCKED, clken is forced 0 and clkout is forced 0.
- incr = 0: acc frozen, clken never asserts, clkout = MSB of the loaded phase.
- cfg_ready = 1 in every state except RESET. Writes are legal while locked and do not disturb the outputs until commit.

## Timing
- Reset values: clken 0, clkout 0, locked 0, cfg_ready 0, cfg_err 0, state RESET.
- locked:
  - Rises exactly LOCK_CYCLES cycles after the first rising edge with rst low.
  - After a commit it falls the next cycle and rises LOCK_CYCLES cycles after the commit edge.
- First accumulator update happens on the edge that ends the first LOCKED cycle. clken is registered, so it asserts 1 cycle after the wrapping add.
- Wrap period is exact on average: over 2^ACC_W cycles there are exactly incr clken pulses.
- Channels with equal phase and commensurate incr remain phase-locked across every commit.
- rst mid-operation: everything returns to reset values on the next edge, shadows included.
- cfg_err latency: 1 cycle after the accepted write.

## Structure
- Package clk_enable_synth_pkg holds:
  - state enum ST_RESET, ST_SETTLE, ST_LOCKED
  - a function computing the CH_W clog2 with floor 1
- Sub-module clk_enable_synth_chan: one accumulator channel.
  - Inputs: run, load, phase, incr.
  - Outputs: clken, clkout.
  - Instantiated NUM_CLOCKS times in a generate loop.
- The top level contains the supervisor FSM, lock counter, shadow registers and cfg decode.

## Test plan
- Reset, then LOCK_CYCLES=16 with no config: locked rises exactly 16 cycles after rst drops; clken and clkout stay 0.
- ACC_W=4, ch0 incr=4 phase=0, commit: locked after 16 cycles; clken[0] pulses on the 4th cycle after locked and every 4 cycles after; clkout[0] is high 2 of every 4 cycles.
- ACC_W=32, ch1 incr=0x5555_5555: count 3·2^10 cycles, clken[1] fires 1023 or 1024 times with a pulse spacing of only 3 or 4 cycles; outputs stay gated 0 during the SETTLE after commit.
- Write to cfg_chan=NUM_CLOCKS: cfg_err pulses for 1 cycle, shadows unchanged; a same-cycle write+commit to ch2 uses the new value.
- Commit at cycle 5 of SETTLE: lock count restarts and locked rises 16 cycles after the second commit.
- Assert rst while LOCKED and mid-stream: all outputs are 0 the next cycle; after release, channels output nothing until reprogrammed.
